// File: rtl/up3_dbg_pkg.sv
// rtl/up3_dbg_pkg.sv - shared defaults, index-width helper and debounce state type for the debug pager
package up3_dbg_pkg;

    localparam int DATA_W_DEF       = 8;
    localparam int N_FIELDS_DEF     = 3;
    localparam int N_PAGES_DEF      = 4;
    localparam int LED_W_DEF        = 10;
    localparam int DEBOUNCE_CYC_DEF = 50000;
    localparam int ROTATE_CYC_DEF   = 50000000;

    // Wide enough for any practical debounce period at board clock rates.
    localparam int DEB_CNT_W = 32;

    typedef struct packed {
        logic [1:0]           sync;
        logic                 stable;
        logic [DEB_CNT_W-1:0] cnt;
    } deb_state_t;

    function automatic int page_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/up3_dbg_pager_key_debounce.sv
// rtl/up3_dbg_pager_key_debounce.sv - synchronise, debounce and edge-detect one active-low key
module key_debounce
    import up3_dbg_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic press
);

    deb_state_t st;
    logic       stable_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st.sync   <= 2'b11;
            st.stable <= 1'b1;
            st.cnt    <= '0;
            stable_d  <= 1'b1;
            press     <= 1'b0;
        end else begin
            st.sync  <= {st.sync[0], raw_n};
            stable_d <= st.stable;
            // Only a high-to-low move of the accepted level is a press.
            press    <= stable_d & ~st.stable;
            if (st.sync[1] == st.stable) begin
                st.cnt <= '0;
            end else if (st.cnt == DEB_CNT_W'(DEBOUNCE_CYC - 1)) begin
                st.stable <= st.sync[1];
                st.cnt    <= '0;
            end else begin
                st.cnt <= st.cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/up3_dbg_pager.sv
// rtl/up3_dbg_pager.sv - paged debug display controller with auto-rotate, hold and single-step pulse
module up3_dbg_pager
    import up3_dbg_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int N_FIELDS     = N_FIELDS_DEF,
    parameter int N_PAGES      = N_PAGES_DEF,
    parameter int LED_W        = LED_W_DEF,
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int ROTATE_CYC   = ROTATE_CYC_DEF
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  page_btn,
    input  logic                                  step_btn,
    input  logic                                  mode_auto,
    input  logic                                  hold,
    input  logic [N_PAGES*N_FIELDS*DATA_W-1:0]    page_data,
    input  logic [N_PAGES*(LED_W-2)-1:0]          page_leds,
    output logic [N_FIELDS*DATA_W-1:0]            field_out,
    output logic [LED_W-1:0]                      led_out,
    output logic [page_w(N_PAGES)-1:0]            page_idx,
    output logic                                  step_pulse
);

    localparam int PL_W  = LED_W - 2;
    localparam int FW    = N_FIELDS * DATA_W;
    localparam int PW    = page_w(N_PAGES);
    localparam int ROT_W = $clog2(ROTATE_CYC);

    logic             page_press;
    logic             tick;
    logic [ROT_W-1:0] rot_cnt;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_page_key (
        .clk   (clk),
        .reset (reset),
        .raw_n (page_btn),
        .press (page_press)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step_key (
        .clk   (clk),
        .reset (reset),
        .raw_n (step_btn),
        .press (step_pulse)
    );

    assign tick = mode_auto && (rot_cnt == ROT_W'(ROTATE_CYC - 1));

    // A manual press restarts the rotation period so the user gets a full dwell.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rot_cnt <= '0;
        end else if (!mode_auto || page_press || tick) begin
            rot_cnt <= '0;
        end else begin
            rot_cnt <= rot_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            page_idx <= '0;
        end else if (page_press || tick) begin
            page_idx <= (page_idx == PW'(N_PAGES - 1)) ? '0 : page_idx + 1'b1;
        end
    end

    // Mode/hold indicator bits track live inputs even while the page view is frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            field_out <= '0;
            led_out   <= '0;
        end else begin
            led_out[PL_W+1] <= mode_auto;
            led_out[PL_W]   <= hold;
            if (!hold) begin
                field_out          <= page_data[page_idx*FW +: FW];
                led_out[PL_W-1:0]  <= page_leds[page_idx*PL_W +: PL_W];
            end
        end
    end

endmodule

// File: tb/tb_up3_dbg_pager.sv
// tb/tb_up3_dbg_pager.sv - scoreboard bench for up3_dbg_pager against a run-length/period reference model
module tb_up3_dbg_pager;

    localparam int DW  = 8;
    localparam int NF  = 3;
    localparam int NP  = 4;
    localparam int LW  = 10;
    localparam int PLW = LW - 2;
    localparam int FW  = NF * DW;
    localparam int DEB = 4;
    localparam int ROT = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              page_btn = 1'b1;
    logic              step_btn = 1'b1;
    logic              mode_auto = 1'b0;
    logic              hold = 1'b0;
    logic [NP*FW-1:0]  page_data;
    logic [NP*PLW-1:0] page_leds;
    logic [FW-1:0]     field_out;
    logic [LW-1:0]     led_out;
    logic [1:0]        page_idx;
    logic              step_pulse;

    up3_dbg_pager #(
        .DATA_W(DW), .N_FIELDS(NF), .N_PAGES(NP), .LED_W(LW),
        .DEBOUNCE_CYC(DEB), .ROTATE_CYC(ROT)
    ) dut (
        .clk(clk), .reset(reset), .page_btn(page_btn), .step_btn(step_btn),
        .mode_auto(mode_auto), .hold(hold), .page_data(page_data), .page_leds(page_leds),
        .field_out(field_out), .led_out(led_out), .page_idx(page_idx), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    page;
        logic [FW-1:0] fields;
        logic [LW-1:0] leds;
        logic          step;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: edges are numbered, a key is accepted after DEB
    // consecutive differing samples seen two edges late, rotation is a period from an anchor edge.
    int            n = 0;
    logic [1:0]    hist [2];
    logic          stab [2];
    int            run [2];
    int            low_edge [2];
    int            anchor;
    int            m_page;
    logic [FW-1:0] m_fields;
    logic [PLW-1:0] m_pleds;
    logic          m_mode, m_hold;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            hist[k] = 2'b11; stab[k] = 1'b1; run[k] = 0; low_edge[k] = -100;
        end
        anchor = n; m_page = 0; m_fields = '0; m_pleds = '0; m_mode = 1'b0; m_hold = 1'b0;
    endtask

    task automatic model_edge();
        exp_t e;
        logic sv, raw, pg_press, tk;
        for (int k = 0; k < 2; k++) begin
            raw = (k == 0) ? page_btn : step_btn;
            sv = hist[k][1];
            hist[k] = {hist[k][0], raw};
            if (sv != stab[k]) begin
                run[k]++;
                if (run[k] == DEB) begin
                    stab[k] = sv; run[k] = 0;
                    if (!sv) low_edge[k] = n;
                end
            end else begin
                run[k] = 0;
            end
        end
        pg_press = (low_edge[0] == n - 2);
        tk = mode_auto && ((n - anchor) % ROT == ROT - 1);
        if (!hold) begin
            m_fields = page_data[m_page*FW +: FW];
            m_pleds  = page_leds[m_page*PLW +: PLW];
        end
        m_mode = mode_auto; m_hold = hold;
        if (!mode_auto || pg_press) anchor = n + 1;
        if (pg_press || tk) m_page = (m_page + 1) % NP;
        e.page = 2'(m_page); e.fields = m_fields; e.leds = {m_mode, m_hold, m_pleds};
        e.step = (low_edge[1] == n - 1);
        exp_q.push_back(e);
        n++;
    endtask

    task automatic tick_cycle();
        model_edge();
        @(negedge clk);
    endtask

    task automatic run_cycles(input int c);
        repeat (c) tick_cycle();
    endtask

    task automatic key_pulse(input int k, input int low, input int high);
        if (k == 0) page_btn = 1'b0; else step_btn = 1'b0;
        run_cycles(low);
        if (k == 0) page_btn = 1'b1; else step_btn = 1'b1;
        run_cycles(high);
    endtask

    task automatic check_now(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic reset_and_check();
        reset = 1'b0;
        #1;
        check_now("rst_page_idx", 64'(page_idx), 64'd0);
        check_now("rst_field_out", 64'(field_out), 64'd0);
        check_now("rst_led_out", 64'(led_out), 64'd0);
        check_now("rst_step_pulse", 64'(step_pulse), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (page_idx !== e.page || field_out !== e.fields || led_out !== e.leds || step_pulse !== e.step) begin
                miscompares++;
                $display("FAIL cycle@%0t: page_idx %0d exp %0d, field_out %h exp %h, led_out %h exp %h, step_pulse %b exp %b",
                         $time, page_idx, e.page, field_out, e.fields, led_out, e.leds, step_pulse, e.step);
            end
        end
    end

    initial begin
        int seg [2];
        int idx, guard;
        for (int p = 0; p < NP; p++)
            for (int f = 0; f < NF; f++)
                page_data[(p*NF+f)*DW +: DW] = 8'((p << 4) | f);
        for (int p = 0; p < NP; p++) page_leds[p*PLW +: PLW] = 8'($urandom);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_and_check();
        run_cycles(5);

        // Step key: long hold gives one pulse, short glitches give none.
        key_pulse(1, 20, 10);
        repeat (3) key_pulse(1, 3, 3);
        run_cycles(6);

        // Four clean page presses wrap back to page 0.
        repeat (4) key_pulse(0, 6, 6);
        run_cycles(4);

        // Auto rotation, then a manual press timed to land on a tick.
        mode_auto = 1'b1;
        run_cycles(35);
        guard = 0;
        while (((n + DEB + 3 - anchor) % ROT != ROT - 1) && guard < 2*ROT) begin
            tick_cycle();
            guard++;
        end
        key_pulse(0, 6, 8);
        run_cycles(25);
        mode_auto = 1'b0;
        run_cycles(3);

        // Hold on page 1 while data changes and the page moves on.
        key_pulse(0, 6, 6);
        hold = 1'b1;
        run_cycles(2);
        page_data = {$urandom, $urandom, $urandom};
        page_leds = {$urandom};
        key_pulse(0, 6, 6);
        key_pulse(0, 6, 6);
        hold = 1'b0;
        run_cycles(4);

        // Reset in the middle of a step-key debounce and a rotation.
        mode_auto = 1'b1;
        run_cycles(4);
        step_btn = 1'b0;
        run_cycles(4);
        reset_and_check();
        run_cycles(10);
        step_btn = 1'b1;
        run_cycles(8);

        // Randomised mix of keys, hold, mode and data traffic.
        seg[0] = 3; seg[1] = 5;
        for (int c = 0; c < 500; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (seg[k] == 0) begin
                    if (k == 0) page_btn = ~page_btn; else step_btn = ~step_btn;
                    seg[k] = $urandom_range(1, 9);
                end
                seg[k]--;
            end
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, NP*NF-1);
                page_data[idx*DW +: DW] = 8'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                idx = $urandom_range(0, NP-1);
                page_leds[idx*PLW +: PLW] = 8'($urandom);
            end
            if ($urandom_range(0, 19) == 0) hold = ~hold;
            if ($urandom_range(0, 39) == 0) mode_auto = ~mode_auto;
            tick_cycle();
        end

        @(posedge clk);
        #3;
        check_now("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/up3_dbg_pager.md
# up3_dbg_pager

Parametrised board-level debug display controller for the up3 CPU with control unit. It replaces the fixed two-mode KEY-selected display multiplexer with N_PAGES selectable pages of N_FIELDS byte fields plus a per-page LED word. Page selection is by debounced button or by timed auto-rotation, and a hold mode freezes a snapshot. It also generates a clean one-cycle single-step pulse for the CPU clock-enable. It sits between the up3 core's debug busses and the dualseg7 display drivers and LEDR.

## Interface
- DATA_W, 8: width of one display field (one dualseg7 pair)
- N_FIELDS, 3: fields per page
- N_PAGES, 4: number of pages; must be ≥ 2
- LED_W, 10: LEDR width; page LED word width is PL_W = LED_W-2
- DEBOUNCE_CYC, 50000: cycles a key must be stable to be accepted; must be ≥ 2
- ROTATE_CYC, 50000000: auto-rotate period in cycles; must be ≥ 2

- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- page_btn  in  1  raw page key, active-low, asynchronous to clk
- step_btn  in  1  raw step key, active-low, asynchronous to clk
- mode_auto  in  1  level; 1 selects auto-rotate
- hold  in  1  level; 1 freezes displayed outputs
- page_data  in  N_PAGES*N_FIELDS*DATA_W  field f of page p at bits [(p*N_FIELDS+f)*DATA_W +: DATA_W]
- page_leds  in  N_PAGES*PL_W  LED word of page p at [p*PL_W +: PL_W]
- field_out  out  N_FIELDS*DATA_W  displayed fields, to dualseg7 instances
- led_out  out  LED_W  bits [PL_W-1:0] page LEDs; bit PL_W = hold; bit PL_W+1 = mode_auto
- page_idx  out  $clog2(N_PAGES)  current page
- step_pulse  out  1  one-cycle pulse per accepted step-key press

## Operation
- Reset values: page_idx=0, field_out=0, led_out=0, step_pulse=0, rotate counter=0. Debounce sync flops and stable level reset to 1 (released).
- Debounce, per key:
  - Two-flop synchroniser.
  - Counter clears whenever the synchronised value equals the stable level.
  - On each edge where they differ: if cnt==DEBOUNCE_CYC-1, then stable<=sync and cnt<=0; else cnt++.
  - A glitch shorter than DEBOUNCE_CYC cycles produces no event.
- Press strobe: registered falling edge of the stable level. It is exactly one cycle wide. Releases produce no event.
- step_pulse is the step key's press strobe. It is not gated by hold or mode.
- Page advance: page_idx <= (page_idx==N_PAGES-1) ? 0 : page_idx+1.
  - Triggered by a page press strobe, or by a rotate tick when mode_auto=1.
  - A press and a tick in the same cycle advance by one only.
- Rotate counter:
  - Runs only when mode_auto=1 and wraps at ROTATE_CYC-1, where it issues a tick.
  - Clears when mode_auto=0 and on any manual press.
  - Entering auto mode therefore waits a full ROTATE_CYC before the first tick.
- Display register:
  - Each cycle with hold=0, field_out and led_out[PL_W-1:0] load the slice of page_idx.
  - With hold=1 these keep their last value. page_idx still advances.
  - On hold release, the live data of the current page loads at the next edge.
- led_out[PL_W+1:PL_W] are registered copies of mode_auto and hold. They update regardless of hold.

## Timing
- Let a key's raw low first be sampled at edge 1. Then:
  - sync output goes low after edge 2.
  - stable flips at edge DEBOUNCE_CYC+2.
  - The press strobe (and step_pulse) is high during the cycle following edge DEBOUNCE_CYC+3.
- page_idx updates at edge DEBOUNCE_CYC+4. field_out shows the new page after edge DEBOUNCE_CYC+5.
- Auto mode:
  - A tick is asserted in the cycle the counter equals ROTATE_CYC-1.
  - page_idx changes on that edge and field_out one edge later.
  - The period is ROTATE_CYC cycles.
- page_data changes appear on field_out with 1-cycle latency when hold=0.
- Asserting reset mid-debounce or mid-rotation discards all progress immediately. The first press after deassertion needs the full DEBOUNCE_CYC.

## Structure
- Package up3_dbg_pkg holds:
  - default parameter constants
  - the page-index width function
  - a typedef for the per-key debounce state (sync, stable, cnt)
- Sub-module key_debounce (parameter DEBOUNCE_CYC; ports clk, reset, raw_n, press) is instantiated twice. It contains the synchroniser, counter and registered press strobe.
- The top level holds the page counter, rotate counter, display/hold register and output slicing.

## Test plan
All scenarios use DEBOUNCE_CYC=4, ROTATE_CYC=10, N_PAGES=4, DATA_W=8, N_FIELDS=3.
- Reset: drive reset=0 mid-run. Required: all outputs 0 and page_idx=0 immediately. After release and no keys, outputs show page 0 data after one edge.
- Step key:
  - Held low for 20 cycles: exactly one step_pulse, high in the cycle after edge 7. Release produces none.
  - Low pulses of 3 cycles: no pulse.
- Page wrap: four clean page presses. Required: page_idx 1,2,3,0. With page p field f preset to 8'h{p}{f}, field_out = {8'h02,8'h01,8'h00} after wrap.
- Auto rotate: set mode_auto=1. Required: page_idx advances every 10 cycles. A manual press landing on a tick cycle advances once only, and the next tick follows 10 cycles later.
- Hold: set hold=1 on page 1, then change page_data and press page twice. Required: field_out/led_out[7:0] unchanged, led_out[8]=1, page_idx=3. Releasing hold shows page 3 data after one edge.
